// File: rtl/t03_mem_pkg.sv
// t03_mem_pkg: shared state type, byte-enable constant and lane helper for the memory-access stage.
package t03_mem_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} mem_state_t;

    localparam logic [3:0] WORD_SEL = 4'hF;

    function automatic logic [7:0] lane_byte(input logic [31:0] w, input logic [1:0] off);
        return w[8*off +: 8];
    endfunction

endpackage

// File: rtl/t03_mem_access.sv
// t03_mem_access: one bus request/ack transaction per load or store, stalling the pipeline until it completes.
module t03_mem_access
    import t03_mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ALU_value,
    input  logic [31:0] store_data,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        load_byte,
    input  logic        store_byte,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_sel,
    output logic        bus_read,
    output logic        bus_write,
    output logic [31:0] memory_value,
    output logic        stall,
    output logic        bus_error
);

    mem_state_t r_state, w_next;
    logic [7:0] r_cnt;
    logic [1:0] r_off;
    logic       r_lb;

    logic       w_req, w_byte, w_mis, w_go, w_tmo;
    logic [7:0] w_cnt_inc;
    logic [3:0] w_sel;

    // A simultaneous read and write is treated as a store, so the store's width decides alignment.
    assign w_req     = mem_read | mem_write;
    assign w_byte    = mem_write ? store_byte : load_byte;
    assign w_mis     = w_req & (ALU_value[1:0] != 2'b00) & ~w_byte;
    assign w_go      = w_req & ~w_mis;
    assign w_cnt_inc = r_cnt + 8'd1;
    assign w_tmo     = (r_state == BUSY) & ~bus_ack & (w_cnt_inc == 8'(TIMEOUT_CYCLES));
    assign w_sel     = w_byte ? (4'b0001 << ALU_value[1:0]) : WORD_SEL;

    always_comb begin
        w_next = IDLE;
        stall  = 1'b0;
        case (r_state)
            IDLE: begin
                w_next = w_go ? BUSY : IDLE;
                stall  = w_go;
            end
            BUSY: begin
                w_next = (bus_ack | w_tmo) ? DONE : BUSY;
                stall  = 1'b1;
            end
            default: w_next = IDLE;
        endcase
        if (rst) stall = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_off        <= '0;
            r_lb         <= 1'b0;
            bus_addr     <= '0;
            bus_wdata    <= '0;
            bus_sel      <= '0;
            bus_read     <= 1'b0;
            bus_write    <= 1'b0;
            memory_value <= '0;
            bus_error    <= 1'b0;
        end else begin
            r_state   <= w_next;
            bus_error <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_mis) begin
                        bus_error <= 1'b1;
                    end else if (w_go) begin
                        bus_addr  <= {ALU_value[31:2], 2'b00};
                        bus_wdata <= mem_write ? (store_byte ? {4{store_data[7:0]}} : store_data) : '0;
                        bus_sel   <= w_sel;
                        bus_read  <= ~mem_write;
                        bus_write <= mem_write;
                        r_off     <= ALU_value[1:0];
                        r_lb      <= load_byte;
                        r_cnt     <= '0;
                    end
                end
                BUSY: begin
                    if (bus_ack) begin
                        bus_read  <= 1'b0;
                        bus_write <= 1'b0;
                        if (bus_read)
                            memory_value <= r_lb ? {24'b0, lane_byte(bus_rdata, r_off)} : bus_rdata;
                    end else if (w_tmo) begin
                        bus_read  <= 1'b0;
                        bus_write <= 1'b0;
                        bus_error <= 1'b1;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_t03_mem_access.sv
// tb_t03_mem_access: directed vector table plus hand sequences for misalignment and reset mid-transaction.
module tb_t03_mem_access;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] ALU_value = '0, store_data = '0, bus_rdata = '0;
    logic        mem_read = 1'b0, mem_write = 1'b0, load_byte = 1'b0, store_byte = 1'b0, bus_ack = 1'b0;
    logic [31:0] bus_addr, bus_wdata, memory_value;
    logic [3:0]  bus_sel;
    logic        bus_read, bus_write, stall, bus_error;

    int total = 0;
    int bad   = 0;

    t03_mem_access #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .ALU_value(ALU_value), .store_data(store_data),
        .mem_read(mem_read), .mem_write(mem_write), .load_byte(load_byte), .store_byte(store_byte),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_sel(bus_sel), .bus_read(bus_read), .bus_write(bus_write), .memory_value(memory_value),
        .stall(stall), .bus_error(bus_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] sdata;
        logic        rd, wr, lb, sb;
        logic [31:0] rdata;
        int          waits;
        logic [31:0] eaddr;
        logic [3:0]  esel;
        logic [31:0] ewdata;
        logic        erd, ewr;
        logic [31:0] emv;
        int          estall;
        logic        eerr;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", n, a, e);
        end
    endtask

    task automatic clear_req();
        mem_read = 1'b0; mem_write = 1'b0; load_byte = 1'b0; store_byte = 1'b0;
    endtask

    task automatic run(input int idx, input vec_t v);
        int  st;
        bit  done;
        @(posedge clk); #1;
        ALU_value = v.addr; store_data = v.sdata; bus_rdata = v.rdata;
        mem_read = v.rd; mem_write = v.wr; load_byte = v.lb; store_byte = v.sb; bus_ack = 1'b0;
        @(negedge clk);
        st = int'(stall);
        done = 1'b0;
        for (int k = 1; k <= 20 && !done; k++) begin
            @(posedge clk); #1;
            bus_ack = (k == v.waits + 1);
            @(negedge clk);
            if (k == 1) begin
                chk($sformatf("v%0d addr", idx), bus_addr, v.eaddr);
                chk($sformatf("v%0d sel", idx), {28'b0, bus_sel}, {28'b0, v.esel});
                chk($sformatf("v%0d wdata", idx), bus_wdata, v.ewdata);
                chk($sformatf("v%0d rd", idx), {31'b0, bus_read}, {31'b0, v.erd});
                chk($sformatf("v%0d wr", idx), {31'b0, bus_write}, {31'b0, v.ewr});
            end
            if (stall) st++;
            else done = 1'b1;
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL v%0d timeout_wait got=no_done exp=done", idx);
        end
        chk($sformatf("v%0d stall_cycles", idx), st, v.estall);
        chk($sformatf("v%0d mv", idx), memory_value, v.emv);
        chk($sformatf("v%0d err", idx), {31'b0, bus_error}, {31'b0, v.eerr});
        chk($sformatf("v%0d strobes_off", idx), {30'b0, bus_read, bus_write}, 32'd0);
        @(posedge clk); #1;
        clear_req(); bus_ack = 1'b0;
        @(negedge clk);
        chk($sformatf("v%0d noreissue", idx), {30'b0, bus_read, bus_write}, 32'd0);
    endtask

    initial begin
        //            addr          sdata         rd wr lb sb rdata        waits eaddr         sel      wdata         rd wr mv            st eerr
        vecs[0] = '{32'h100, 32'h0,        1, 0, 0, 0, 32'hDEADBEEF, 0,   32'h100, 4'hF,    32'h0,        1, 0, 32'hDEADBEEF, 2, 0};
        vecs[1] = '{32'h203, 32'h0,        1, 0, 1, 0, 32'h11223344, 1,   32'h200, 4'b1000, 32'h0,        1, 0, 32'h11,       3, 0};
        vecs[2] = '{32'h301, 32'h000000AB, 0, 1, 0, 1, 32'hFFFFFFFF, 3,   32'h300, 4'b0010, 32'hABABABAB, 0, 1, 32'h11,       5, 0};
        vecs[3] = '{32'h404, 32'h12345678, 1, 1, 0, 0, 32'hFFFFFFFF, 0,   32'h404, 4'hF,    32'h12345678, 0, 1, 32'h11,       2, 0};
        vecs[4] = '{32'h500, 32'h0,        1, 0, 0, 0, 32'h55555555, 255, 32'h500, 4'hF,    32'h0,        1, 0, 32'h11,       5, 1};
        vecs[5] = '{32'h501, 32'h0,        1, 0, 1, 0, 32'hAABBCCDD, 2,   32'h500, 4'b0010, 32'h0,        1, 0, 32'hCC,       4, 0};
        vecs[6] = '{32'h600, 32'h0,        1, 0, 1, 0, 32'h12345678, 0,   32'h600, 4'b0001, 32'h0,        1, 0, 32'h78,       2, 0};
        vecs[7] = '{32'h702, 32'h0,        1, 0, 1, 0, 32'h9ABCDEF0, 0,   32'h700, 4'b0100, 32'h0,        1, 0, 32'hBC,       2, 0};

        mem_read = 1'b1; ALU_value = 32'h100;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst stall", {31'b0, stall}, 32'd0);
        chk("rst addr", bus_addr, 32'd0);
        chk("rst strobes", {27'b0, bus_sel, bus_read, bus_write}, 32'd0);
        chk("rst mv_err", {memory_value[30:0], bus_error}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; clear_req();

        for (int i = 0; i < 8; i++) run(i, vecs[i]);

        @(posedge clk); #1;
        ALU_value = 32'h102; mem_read = 1'b1;
        @(negedge clk);
        chk("mis stall", {31'b0, stall}, 32'd0);
        @(posedge clk); #1;
        clear_req();
        @(negedge clk);
        chk("mis err", {31'b0, bus_error}, 32'd1);
        chk("mis strobes", {30'b0, bus_read, bus_write}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("mis err_pulse", {31'b0, bus_error}, 32'd0);

        @(posedge clk); #1;
        ALU_value = 32'h800; mem_read = 1'b1; bus_ack = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rbusy rd", {31'b0, bus_read}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1; clear_req();
        @(negedge clk);
        chk("rbusy stall_forced", {31'b0, stall}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; bus_ack = 1'b1; bus_rdata = 32'hCAFEF00D;
        @(negedge clk);
        chk("rbusy strobes", {30'b0, bus_read, bus_write}, 32'd0);
        chk("rbusy mv", memory_value, 32'd0);
        chk("rbusy stall", {31'b0, stall}, 32'd0);
        @(posedge clk); #1;
        bus_ack = 1'b0;
        @(negedge clk);
        chk("rbusy late_ack_mv", memory_value, 32'd0);
        chk("rbusy late_ack_idle", {30'b0, bus_read, bus_write}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/t03_mem_access.md
# t03_mem_access

Memory-access stage between the ALU and the writeback mux. Takes the ALU-computed address and store data, runs one request/acknowledge transaction on the data bus per load or store, stalls the pipeline until the transaction completes, and delivers a registered, byte-lane-aligned `memory_value` to writeback. Byte loads are shifted into bits [7:0] so writeback's zero-extension is correct. Byte stores are lane-steered with byte enables.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 255: maximum cycles in BUSY waiting for `bus_ack` before the access is aborted. Legal range 1..255.

Ports:
- `clk`  in  1: single clock. All state updates on the rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `ALU_value`  in  32: byte address of the access.
- `store_data`  in  32: rs2 value to store.
- `mem_read`  in  1: load requested this cycle.
- `mem_write`  in  1: store requested this cycle.
- `load_byte`  in  1: load is a byte access (otherwise word).
- `store_byte`  in  1: store is a byte access (otherwise word).
- `bus_rdata`  in  32: read data from the bus, valid when `bus_ack` is high.
- `bus_ack`  in  1: bus completes the current transaction.
- `bus_addr`  out  32: word-aligned address ({addr[31:2], 2'b00}), registered.
- `bus_wdata`  out  32: write data, registered.
- `bus_sel`  out  4: byte enables, registered.
- `bus_read`  out  1: read strobe, registered.
- `bus_write`  out  1: write strobe, registered.
- `memory_value`  out  32: captured load data, registered; goes to writeback.
- `stall`  out  1: freeze the PC and upstream registers. Combinational.
- `bus_error`  out  1: one-cycle pulse on misaligned word access or timeout.

## Operation
- FSM states: IDLE, BUSY, DONE.
- **IDLE**
  - A request is `mem_read | mem_write`. If both are high, the store wins and the read is ignored.
  - Misaligned word access (`ALU_value[1:0] != 0` and not a byte access): no bus transaction, `bus_error` pulses next cycle, stay in IDLE, `stall` stays 0.
  - Valid request: on the next edge, load the bus output registers and strobes and enter BUSY. Latch `ALU_value[1:0]` and `load_byte` internally.
- **Word access**
  - `bus_sel` = 4'hF.
  - Store: `bus_wdata` = `store_data`.
- **Byte store**
  - `bus_sel` = 4'b0001 << addr[1:0].
  - `bus_wdata` = {4{store_data[7:0]}}.
- **Byte load**
  - `bus_sel` = 4'b0001 << addr[1:0].
  - On ack, `memory_value` = {24'b0, `bus_rdata`[8*addr[1:0] +: 8]}.
- **Word load**: on ack, `memory_value` = `bus_rdata`.
- **BUSY**
  - Strobes, address, data and sel are held constant until `bus_ack`.
  - On `bus_ack`: clear strobes, capture load data (loads only; stores leave `memory_value` unchanged), go to DONE.
  - 8-bit timeout counter: cleared on entry to BUSY, increments each BUSY cycle without ack. When it reaches `TIMEOUT_CYCLES`: clear strobes, pulse `bus_error`, leave `memory_value` unchanged, go to DONE.
- **DONE**
  - Exactly one cycle, `stall` = 0, so the pipeline advances past the instruction.
  - Request inputs are ignored this cycle, so the same instruction is not reissued.
  - Next state is IDLE.
- **Stall equation**: `stall` = (IDLE & valid request) | BUSY. Forced to 0 while `rst` is high.
- `bus_ack` outside BUSY is ignored.

## Timing
- **Reset values** (next edge with `rst` high): state IDLE, all bus outputs 0, `memory_value` 0, `bus_error` 0, counter 0.
- **Reset mid-BUSY**: strobes drop on that edge and no data is captured. A late `bus_ack` is ignored.
- **Minimum access**: request at cycle 0 (stall=1), BUSY at cycle 1 with ack (stall=1), DONE at cycle 2 (stall=0, `memory_value` valid).
  - Load latency is 2 cycles.
  - Each extra wait cycle adds one cycle.
- **Timeout**: `bus_error` is high in the DONE cycle, `TIMEOUT_CYCLES`+1 cycles after the request cycle.
- **Back-to-back requests**: the second request is evaluated in the IDLE cycle after DONE. Minimum issue interval is 3 cycles.

## Structure
- Shared package `t03_mem_pkg`:
  - `mem_state_t` enum (IDLE, BUSY, DONE).
  - `WORD_SEL` = 4'hF.
  - Lane-extract function (byte from a word by a 2-bit offset), reused by any later halfword support.
- No sub-module: FSM, counter and lane logic together fit in one file of roughly 150-200 lines.

## Test plan
- Word load, addr 0x100, `bus_rdata` 0xDEADBEEF, ack in first BUSY cycle → `bus_sel` F, `bus_addr` 0x100; `stall` high 2 cycles; `memory_value` 0xDEADBEEF in DONE.
- Byte load, addr 0x203, `bus_rdata` 0x11223344 → `bus_addr` 0x200, `bus_sel` 4'b1000; `memory_value` 0x00000011.
- Byte store, addr 0x301, `store_data` 0xAB, ack after 3 wait cycles → `bus_sel` 4'b0010, `bus_wdata` 0xABABABAB; `stall` high 5 cycles; `memory_value` unchanged.
- Word load, addr 0x102 → no strobe, `bus_error` pulses once, `stall` stays 0.
- `TIMEOUT_CYCLES`=4, no ack → abort: strobes drop, `bus_error` high in DONE 5 cycles after the request; next request is accepted normally.
- `rst` asserted in the 2nd BUSY cycle of a read → strobes 0 on the next edge, `memory_value` 0; a later ack is ignored and state stays IDLE.
